// File: rtl/fadd_arbiter.sv
// Round-robin arbiter sharing one combinational IEEE754 single-precision adder
// among NREQ requesters, with a 2-edge accept-to-response pipeline.

module fadd (
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y,
  output logic        ovf
);
  logic              w_swap, w_sa, w_sb, w_inc;
  logic [31:0]       w_a, w_b;
  logic [7:0]        w_ea, w_eb, w_d;
  logic [4:0]        w_dc, w_lz;
  logic [23:0]       w_ma, w_mb;
  logic [49:0]       w_wide;
  logic [26:0]       w_mb_al, w_norm;
  logic [27:0]       w_sum;
  logic [24:0]       w_mant;
  logic [22:0]       w_frac;
  logic signed [9:0] w_exp;

  always_comb begin
    w_swap = x2[30:0] > x1[30:0];
    w_a    = w_swap ? x2 : x1;
    w_b    = w_swap ? x1 : x2;
    w_sa   = w_a[31];
    w_sb   = w_b[31];
    w_ea   = (w_a[30:23] == 8'd0) ? 8'd1 : w_a[30:23];
    w_eb   = (w_b[30:23] == 8'd0) ? 8'd1 : w_b[30:23];
    w_ma   = {w_a[30:23] != 8'd0, w_a[22:0]};
    w_mb   = {w_b[30:23] != 8'd0, w_b[22:0]};
    w_d    = w_ea - w_eb;
    w_dc   = (w_d > 8'd31) ? 5'd31 : w_d[4:0];
    // Align smaller operand keeping guard, round and a sticky OR of shifted-out bits
    w_wide  = {w_mb, 26'd0} >> w_dc;
    w_mb_al = {w_wide[49:24], |w_wide[23:0]};
    w_sum   = (w_sa == w_sb) ? ({1'b0, w_ma, 3'd0} + {1'b0, w_mb_al})
                             : ({1'b0, w_ma, 3'd0} - {1'b0, w_mb_al});
    w_lz = '0;
    for (int unsigned i = 0; i < 27; i++)
      if (w_sum[i]) w_lz = 5'(26 - i);
    if (w_sum[27]) begin
      w_norm = {w_sum[27:2], w_sum[1] | w_sum[0]};
      w_exp  = $signed({2'b00, w_ea}) + 10'sd1;
    end else begin
      w_norm = w_sum[26:0] << w_lz;
      w_exp  = $signed({2'b00, w_ea}) - $signed({5'd0, w_lz});
    end
    // Round to nearest, ties to even
    w_inc  = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_mant = {1'b0, w_norm[26:3]} + {24'd0, w_inc};
    if (w_mant[24]) begin
      w_exp  = w_exp + 10'sd1;
      w_frac = w_mant[23:1];
    end else begin
      w_frac = w_mant[22:0];
    end
    ovf = 1'b0;
    if (w_sum == 28'd0)          y = '0;
    else if (w_exp >= 10'sd255) begin
      y   = {w_sa, 8'hFF, 23'd0};
      ovf = 1'b1;
    end
    else if (w_exp <= 10'sd0)    y = {w_sa, 31'd0};
    else                         y = {w_sa, w_exp[7:0], w_frac};
  end
endmodule

module fadd_arbiter #(
  parameter int NREQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [32*NREQ-1:0] req_x1,
  input  logic [32*NREQ-1:0] req_x2,
  output logic [NREQ-1:0]    rsp_valid,
  input  logic [NREQ-1:0]    rsp_ready,
  output logic [32*NREQ-1:0] rsp_y,
  output logic [NREQ-1:0]    rsp_ovf,
  output logic               busy
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUED, DONE} slot_t;

  slot_t               r_slot     [NREQ];
  slot_t               w_slot_nxt [NREQ];
  logic [PW-1:0]       r_rr_ptr, w_gnt_id, w_idx;
  logic                w_gnt_v, w_busy_nxt;
  logic [NREQ-1:0]     w_elig, w_grant;
  logic                r_op_v;
  logic [PW-1:0]       r_op_id;
  logic [31:0]         r_op_x1, r_op_x2, w_fy;
  logic                w_fovf;
  logic [32*NREQ-1:0]  r_rsp_y;
  logic [NREQ-1:0]     r_rsp_ovf;
  logic                r_busy;

  fadd u_fadd (.x1(r_op_x1), .x2(r_op_x2), .y(w_fy), .ovf(w_fovf));

  always_comb begin
    w_elig   = '0;
    w_grant  = '0;
    w_gnt_id = '0;
    w_gnt_v  = 1'b0;
    w_idx    = '0;
    for (int unsigned i = 0; i < NREQ; i++)
      w_elig[i] = req_valid[i] && (r_slot[i] == IDLE);
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = PW'((32'(r_rr_ptr) + k) % NREQ);
      if (!w_gnt_v && w_elig[w_idx]) begin
        w_gnt_v  = 1'b1;
        w_gnt_id = w_idx;
      end
    end
    if (rst) w_gnt_v = 1'b0;
    if (w_gnt_v) w_grant[w_gnt_id] = 1'b1;
  end

  always_comb begin
    w_busy_nxt = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_slot_nxt[i] = r_slot[i];
      case (r_slot[i])
        IDLE:    if (w_grant[i]) w_slot_nxt[i] = ISSUED;
        ISSUED:  if (r_op_v && r_op_id == PW'(i)) w_slot_nxt[i] = DONE;
        DONE:    if (rsp_ready[i]) w_slot_nxt[i] = IDLE;
        default: w_slot_nxt[i] = IDLE;
      endcase
      if (w_slot_nxt[i] != IDLE) w_busy_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREQ; i++) r_slot[i] <= IDLE;
      r_rr_ptr  <= '0;
      r_op_v    <= 1'b0;
      r_op_id   <= '0;
      r_op_x1   <= '0;
      r_op_x2   <= '0;
      r_rsp_y   <= '0;
      r_rsp_ovf <= '0;
      r_busy    <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) r_slot[i] <= w_slot_nxt[i];
      r_busy <= w_busy_nxt;
      r_op_v <= w_gnt_v;
      if (w_gnt_v) begin
        r_rr_ptr <= PW'((32'(w_gnt_id) + 1) % NREQ);
        r_op_id  <= w_gnt_id;
        r_op_x1  <= req_x1[32*w_gnt_id +: 32];
        r_op_x2  <= req_x2[32*w_gnt_id +: 32];
      end
      if (r_op_v) begin
        r_rsp_y[32*r_op_id +: 32] <= w_fy;
        r_rsp_ovf[r_op_id]        <= w_fovf;
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int unsigned i = 0; i < NREQ; i++) rsp_valid[i] = (r_slot[i] == DONE);
  end

  assign req_ready = w_grant;
  assign rsp_y     = r_rsp_y;
  assign rsp_ovf   = r_rsp_ovf;
  assign busy      = r_busy;
endmodule

// File: tb/tb_fadd_arbiter.sv
// Directed bench for fadd_arbiter: table of single-requester adds plus
// sequences for round-robin order, response hold, reset abort and pointer wrap.

module tb_fadd_arbiter;
  localparam int NREQ = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid, req_ready, rsp_valid, rsp_ready, rsp_ovf;
  logic [32*NREQ-1:0] req_x1, req_x2, rsp_y;
  logic               busy;
  int                 n_checks = 0;
  int                 n_errors = 0;

  fadd_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x1(req_x1), .req_x2(req_x2), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_ovf(rsp_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] y;
    logic [31:0] mask;
    logic        ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic set_ops(input int id, input logic [31:0] a, input logic [31:0] b);
    req_x1[32*id +: 32] = a;
    req_x2[32*id +: 32] = b;
  endtask

  initial begin
    vecs[0] = '{0, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'hFFFFFFFF, 1'b0};
    vecs[1] = '{1, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 32'h7F800000, 1'b1};
    vecs[2] = '{2, 32'h40000000, 32'h3F800000, 32'h40400000, 32'hFFFFFFFF, 1'b0};
    vecs[3] = '{3, 32'h3FC00000, 32'h3FC00000, 32'h40400000, 32'hFFFFFFFF, 1'b0};
    vecs[4] = '{1, 32'h40400000, 32'hBF800000, 32'h40000000, 32'hFFFFFFFF, 1'b0};
    vecs[5] = '{0, 32'hC0000000, 32'h40000000, 32'h00000000, 32'h7FFFFFFF, 1'b0};

    req_x1 = '0;
    req_x2 = '0;
    rst = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = '0;
    #1;
    chk("ready_in_reset", 32'(req_ready), 32'h0);
    tick();
    tick();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rsp_y", rsp_y[31:0] | rsp_y[63:32] | rsp_y[95:64] | rsp_y[127:96], 32'h0);
    chk("rst_rsp_ovf", 32'(rsp_ovf), 32'h0);
    req_valid = '0;
    rst = 1'b0;
    #1;

    // single-requester operation vectors
    for (int v = 0; v < 6; v++) begin
      set_ops(vecs[v].id, vecs[v].x1, vecs[v].x2);
      req_valid = 4'(1 << vecs[v].id);
      #1;
      chk("accept_ready", 32'(req_ready), 32'(1 << vecs[v].id));
      tick();
      req_valid = '0;
      set_ops(vecs[v].id, $urandom, $urandom);
      #1;
      chk("issued_no_rsp", 32'(rsp_valid), 32'h0);
      chk("issued_busy", 32'(busy), 32'h1);
      tick();
      chk("rsp_valid", 32'(rsp_valid), 32'(1 << vecs[v].id));
      chk("rsp_y", rsp_y[32*vecs[v].id +: 32] & vecs[v].mask, vecs[v].y);
      chk("rsp_ovf", 32'(rsp_ovf[vecs[v].id]), 32'(vecs[v].ovf));
      rsp_ready = 4'(1 << vecs[v].id);
      tick();
      rsp_ready = '0;
      #1;
      chk("consumed_valid", 32'(rsp_valid), 32'h0);
      chk("consumed_busy", 32'(busy), 32'h0);
      chk("consumed_y_kept", rsp_y[32*vecs[v].id +: 32] & vecs[v].mask, vecs[v].y);
    end

    // round-robin across all four with wrap back to 0
    do_reset();
    begin
      logic [3:0] exp_g [5];
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      req_valid = 4'b1111;
      rsp_ready = 4'b1111;
      #1;
      for (int c = 0; c < 5; c++) begin
        chk("rr_grant", 32'(req_ready), 32'(exp_g[c]));
        tick();
      end
    end

    // single requester with rsp_ready tied high: one accept per three cycles
    do_reset();
    begin
      int acc = 0;
      req_valid = 4'b0001;
      rsp_ready = 4'b1111;
      #1;
      for (int c = 0; c < 9; c++) begin
        if (req_ready[0]) acc++;
        tick();
      end
      chk("single_thruput", 32'(acc), 32'd3);
    end

    // response held while rsp_ready low, regrant only after consume
    do_reset();
    set_ops(2, 32'h40000000, 32'h3F800000);
    req_valid = 4'b0100;
    #1;
    chk("hold_accept", 32'(req_ready), 32'h4);
    tick();
    for (int c = 0; c < 10; c++) begin
      set_ops(2, $urandom, $urandom);
      #1;
      chk("hold_no_grant", 32'(req_ready[2]), 32'h0);
      if (c >= 1) begin
        chk("hold_valid", 32'(rsp_valid[2]), 32'h1);
        chk("hold_y", rsp_y[64 +: 32], 32'h40400000);
      end
      tick();
    end
    rsp_ready = 4'b0100;
    #1;
    chk("consume_no_grant", 32'(req_ready[2]), 32'h0);
    tick();
    rsp_ready = '0;
    #1;
    chk("regrant_after", 32'(req_ready), 32'h4);
    chk("regrant_valid_clr", 32'(rsp_valid), 32'h0);
    chk("regrant_y_kept", rsp_y[64 +: 32], 32'h40400000);
    req_valid = '0;
    #1;

    // reset while an op is in flight
    do_reset();
    set_ops(3, 32'h3F800000, 32'h3F800000);
    req_valid = 4'b1000;
    #1;
    chk("abort_accept", 32'(req_ready), 32'h8);
    tick();
    rst = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("abort_ready_rst", 32'(req_ready), 32'h0);
    tick();
    rst = 1'b0;
    req_valid = 4'b1010;
    #1;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_lowest", 32'(req_ready), 32'h2);
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("abort_no_rsp", 32'(rsp_valid), 32'h0);
    end

    // rr_ptr=1 with requesters 0 and 2 pending
    do_reset();
    set_ops(0, 32'h3F800000, 32'h3F800000);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    tick();
    rsp_ready = 4'b0001;
    tick();
    rsp_ready = '0;
    set_ops(0, 32'hC0000000, 32'h40000000);
    set_ops(2, 32'h40000000, 32'h3F800000);
    req_valid = 4'b0101;
    #1;
    chk("ptr1_first", 32'(req_ready), 32'h4);
    tick();
    chk("ptr3_second", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    #1;
    chk("ptr_rsp2", 32'(rsp_valid), 32'h4);
    tick();
    chk("ptr_rsp_both", 32'(rsp_valid), 32'h5);
    chk("ptr_y0", rsp_y[31:0] & 32'h7FFFFFFF, 32'h0);
    chk("ptr_ovf0", 32'(rsp_ovf[0]), 32'h0);
    chk("ptr_y2", rsp_y[64 +: 32], 32'h40400000);
    rsp_ready = 4'b0101;
    tick();
    rsp_ready = '0;
    req_valid = 4'b0011;
    #1;
    chk("ptr_back_to_1", 32'(req_ready), 32'h2);
    req_valid = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
